strobe_period_checker: RTL and testbench
========================================

Name: strobe_period_checker

Overview:
- Receive-side companion to the free-running modulo counter strobe: samples a periodic single-cycle strobe and locks onto its phase.
- Flags early or missing strobes and exports the recovered phase.
- Sits downstream of any counter that asserts a decode pulse once every PERIOD cycles.

Parameters:
- PERIOD, 4, expected cycles between strobes; range 2..2**CW.
- CW, 2, phase counter width.
- LOCK_CNT, 2, consecutive good strobes needed to lock; range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset; 0 clears all state immediately
- strobe_in  input  1  sampled strobe; a pulse is any cycle with strobe_in=1
- locked  output  1  registered; 1 while the state is LOCKED
- err  output  1  registered; one-cycle pulse on loss of lock
- phase  output  CW  ph while locked, else 0
- expect  output  1  combinational; locked && ph==PERIOD-1, predicts a strobe this cycle

Behaviour:
- Internal registers:
  - state in {HUNT, VERIFY, LOCKED}
  - ph[CW-1:0], cycles since the last accepted strobe
  - good[3:0]
- Reset, while reset=0 and asynchronous: state=HUNT, ph=0, good=0, locked=0, err=0; phase=0 and expect=0 follow from this.
- Edge classification, made at each clock edge outside HUNT:
  - GOOD = strobe_in && ph==PERIOD-1
  - EARLY = strobe_in && ph!=PERIOD-1
  - MISS = !strobe_in && ph==PERIOD-1
  - otherwise IDLE
- ph update: any accepted strobe sets ph<=0; IDLE sets ph<=ph+1; HUNT holds ph at 0. ph never exceeds PERIOD-1 and never wraps through 2**CW, because MISS always resolves first.
- HUNT:
  - strobe_in=1 -> VERIFY, ph<=0, good<=0.
  - Otherwise stay.
- VERIFY:
  - GOOD -> good<=good+1, ph<=0; if good+1==LOCK_CNT -> LOCKED.
  - EARLY -> stay in VERIFY; ph<=0, good<=0 (the early pulse becomes the new reference).
  - MISS -> HUNT, good<=0.
  - No err pulse in VERIFY.
- LOCKED:
  - GOOD -> stay, ph<=0.
  - EARLY -> err<=1, VERIFY, ph<=0, good<=0.
  - MISS -> err<=1, HUNT, good<=0.
- err is 1 only for the single cycle after the offending edge; it returns to 0 on the next edge.
- locked timing: locked rises on the edge that accepts the LOCK_CNT-th good strobe and falls on the edge that asserts err.
- Continuous strobe_in=1: every edge in VERIFY is EARLY, so the block never locks.
- LOCK_CNT=1: the first GOOD after HUNT->VERIFY locks.
- Reset asserted mid-operation: immediate return to the reset values; no err pulse is generated.

Optional Feature:
- Macro: STROBE_ERR_COUNT_EN.
- Defined:
  - Adds output port err_cnt[7:0], a saturating count of err pulses.
  - Increments on every edge that sets err<=1; holds at 255.
  - Cleared only by reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package strobe_chk_pkg:
  - state encoding localparams HUNT=2'd0, VERIFY=2'd1, LOCKED=2'd2
  - the 2-bit state width constant
  - the err_cnt width constant (8)
- One sub-module is natural: sat_counter (parameterised width, inc, async active-low reset), instantiated only under STROBE_ERR_COUNT_EN.

Test Plan (PERIOD=4, CW=2, LOCK_CNT=2, strobe_in=1 at cycle N means sampled at edge N):
- Strobes at 0, 4, 8 -> HUNT->VERIFY at edge 0, good=1 at edge 4, locked=1 after edge 8, phase then counts 1,2,3,0, and expect=1 in cycles 11, 15.
- Locked, then strobe at 10 instead of 12 -> err=1 for exactly the cycle after edge 10, locked=0, state=VERIFY, ph=0. Strobes at 14 and 18 relock after edge 18.
- Locked, last strobe at 8, none at 12 -> err=1 after edge 12, locked=0, state=HUNT. A strobe at 13 enters VERIFY.
- strobe_in held 1 for 20 cycles from reset -> locked stays 0 and err stays 0 throughout.
- reset driven to 0 mid-cycle while locked with ph=2 -> locked, phase, err and expect drop to 0 without waiting for clk, and no err pulse follows release.
- With STROBE_ERR_COUNT_EN: 300 induced MISS events -> err_cnt reads 255 and holds. Reset clears it to 0.

Source files
------------

// File: rtl/strobe_chk_pkg.sv
// Shared encodings for strobe_period_checker: FSM state codes, widths and
// the per-edge strobe classification.
package strobe_chk_pkg;

   localparam int STATE_W   = 2;
   localparam int ERR_CNT_W = 8;

   localparam logic [STATE_W-1:0] HUNT   = 2'd0;
   localparam logic [STATE_W-1:0] VERIFY = 2'd1;
   localparam logic [STATE_W-1:0] LOCKED = 2'd2;

   typedef enum logic [1:0] {
      CLS_IDLE,
      CLS_GOOD,
      CLS_EARLY,
      CLS_MISS
   } edge_cls_t;

   function automatic edge_cls_t classify(input logic strobe, input logic at_last);
      if (strobe)       return at_last ? CLS_GOOD : CLS_EARLY;
      else if (at_last) return CLS_MISS;
      else              return CLS_IDLE;
   endfunction

endpackage

// File: rtl/strobe_period_checker_sat_counter.sv
// Saturating up-counter; used as the err pulse counter of strobe_period_checker.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/strobe_period_checker.sv
// Locks onto a periodic single-cycle strobe, flags early/missing strobes and
// exports the recovered phase. Define STROBE_ERR_COUNT_EN to add err_cnt.
module strobe_period_checker
   import strobe_chk_pkg::*;
#(
   parameter int PERIOD   = 4,
   parameter int CW       = 2,
   parameter int LOCK_CNT = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 strobe_in,
   output logic                 locked,
   output logic                 err,
   output logic [CW-1:0]        phase,
   output logic                 expect_strobe
`ifdef STROBE_ERR_COUNT_EN
   ,
   output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

   localparam logic [CW-1:0] PH_LAST     = CW'(PERIOD - 1);
   localparam logic [3:0]    GOOD_TARGET = 4'(LOCK_CNT);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CW-1:0]      ph_q, ph_d;
   logic [3:0]         good_q, good_d, good_inc;
   logic               locked_q, locked_d;
   logic               err_q, err_d;
   edge_cls_t          cls;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its peers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= HUNT;
         ph_q     <= '0;
         good_q   <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ph_q     <= ph_d;
         good_q   <= good_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   assign cls      = classify(strobe_in, ph_q == PH_LAST);
   assign good_inc = good_q + 4'd1;

   // NOTE: every signal gets its hold/default value first so no path through
   // the case statement can infer a latch.
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      good_d  = good_q;
      err_d   = 1'b0;
      case (state_q)
         HUNT: begin
            ph_d = '0;
            if (strobe_in) begin
               state_d = VERIFY;
               good_d  = '0;
            end
         end
         VERIFY: begin
            case (cls)
               CLS_GOOD: begin
                  ph_d   = '0;
                  good_d = good_inc;
                  if (good_inc == GOOD_TARGET) state_d = LOCKED;
               end
               CLS_EARLY: begin
                  ph_d   = '0;
                  good_d = '0;
               end
               CLS_MISS: begin
                  state_d = HUNT;
                  ph_d    = '0;
                  good_d  = '0;
               end
               default: ph_d = ph_q + 1'b1;
            endcase
         end
         LOCKED: begin
            case (cls)
               CLS_GOOD: ph_d = '0;
               CLS_EARLY: begin
                  state_d = VERIFY;
                  ph_d    = '0;
                  good_d  = '0;
                  err_d   = 1'b1;
               end
               CLS_MISS: begin
                  state_d = HUNT;
                  ph_d    = '0;
                  good_d  = '0;
                  err_d   = 1'b1;
               end
               default: ph_d = ph_q + 1'b1;
            endcase
         end
         default: begin
            state_d = HUNT;
            ph_d    = '0;
            good_d  = '0;
         end
      endcase
   end

   assign locked_d = (state_d == LOCKED);

   always_comb begin
      locked        = locked_q;
      err           = err_q;
      phase         = locked_q ? ph_q : '0;
      expect_strobe = locked_q && (ph_q == PH_LAST);
   end

`ifdef STROBE_ERR_COUNT_EN
   sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (reset),
      .inc   (err_d),
      .count (err_cnt)
   );
`endif

endmodule

// File: tb/tb_strobe_period_checker.sv
// Directed bench for strobe_period_checker with a cycle-level reference model
// built on strobe timestamps; define STROBE_ERR_COUNT_EN to cover err_cnt.
module tb_strobe_period_checker;

   localparam int P = 4;
   localparam int L = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       strobe_in = 1'b0;
   logic       locked, err, expect_strobe;
   logic [1:0] phase;
`ifdef STROBE_ERR_COUNT_EN
   logic [7:0] err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   strobe_period_checker #(.PERIOD(P), .CW(2), .LOCK_CNT(L)) dut (
      .clk           (clk),
      .reset         (reset),
      .strobe_in     (strobe_in),
      .locked        (locked),
      .err           (err),
      .phase         (phase),
      .expect_strobe (expect_strobe)
`ifdef STROBE_ERR_COUNT_EN
      ,
      .err_cnt       (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: timestamps of edges and of the last accepted strobe.
   bit m_hunt   = 1'b1;
   bit m_locked = 1'b0;
   bit m_err    = 1'b0;
   int m_n      = -1;
   int m_ref    = 0;
   int m_run    = 0;
   int m_errcnt = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_hunt = 1'b1; m_locked = 1'b0; m_err = 1'b0;
         m_n = -1; m_ref = 0; m_run = 0; m_errcnt = 0;
      end else begin
         m_n++;
         m_err = 1'b0;
         if (m_hunt) begin
            if (strobe_in) begin m_hunt = 1'b0; m_ref = m_n; m_run = 0; end
         end else if (strobe_in && (m_n - m_ref == P)) begin
            m_ref = m_n;
            if (!m_locked) m_run++;
            if (m_run >= L) m_locked = 1'b1;
         end else if (strobe_in) begin
            m_err = m_locked; m_locked = 1'b0; m_run = 0; m_ref = m_n;
         end else if (m_n - m_ref == P) begin
            m_err = m_locked; m_locked = 1'b0; m_run = 0; m_hunt = 1'b1;
         end
         if (m_err && m_errcnt < 255) m_errcnt++;
      end
   end

   function automatic int m_phase();
      return m_locked ? (m_n - m_ref) : 0;
   endfunction

   function automatic bit m_expect();
      return m_locked && (m_n - m_ref == P - 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pin(input string name, input logic [31:0] dut_v, input logic [31:0] mod_v,
                      input logic [31:0] exp_v);
      check({name, "_dut"}, dut_v, exp_v);
      check({name, "_model"}, mod_v, exp_v);
   endtask

   // Compare process: outputs are stable mid-cycle.
   always @(negedge clk) begin
      check("cmp_locked", 32'(locked), 32'(m_locked));
      check("cmp_err", 32'(err), 32'(m_err));
      check("cmp_phase", 32'(phase), 32'(m_phase()));
      check("cmp_expect", 32'(expect_strobe), 32'(m_expect()));
`ifdef STROBE_ERR_COUNT_EN
      check("cmp_err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
   end

   task automatic cyc(input logic s);
      @(negedge clk);
      strobe_in = s;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      strobe_in = 1'b0;
      #1;
      check("rst_locked", 32'(locked), 0);
      check("rst_err", 32'(err), 0);
      check("rst_phase", 32'(phase), 0);
      check("rst_expect", 32'(expect_strobe), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      #2 reset = 1'b0;
      do_reset();

      // Lock on strobes at relative edges 0, 4, 8.
      cyc(1'b1); idle(3);
      cyc(1'b1);
      pin("t1_unlocked_e4", 32'(locked), 32'(m_locked), 0);
      idle(3);
      cyc(1'b1);
      pin("t1_locked_e8", 32'(locked), 32'(m_locked), 1);
      check("t1_phase_e8", 32'(phase), 0);
      cyc(1'b0); pin("t1_phase_e9", 32'(phase), 32'(m_phase()), 1);
      cyc(1'b0); check("t1_phase_e10", 32'(phase), 2);
      cyc(1'b0); check("t1_phase_e11", 32'(phase), 3);
      pin("t1_expect_e11", 32'(expect_strobe), 32'(m_expect()), 1);
      cyc(1'b1); check("t1_phase_e12", 32'(phase), 0);
      check("t1_expect_e12", 32'(expect_strobe), 0);

      // Early strobe two cycles after the last one.
      cyc(1'b0); cyc(1'b1);
      pin("t2_err", 32'(err), 32'(m_err), 1);
      check("t2_locked", 32'(locked), 0);
      check("t2_phase", 32'(phase), 0);
      cyc(1'b0); check("t2_err_clear", 32'(err), 0);
      idle(2); cyc(1'b1);
      check("t2_not_yet", 32'(locked), 0);
      idle(3); cyc(1'b1);
      pin("t2_relock", 32'(locked), 32'(m_locked), 1);

      // Missing strobe.
      idle(3); cyc(1'b0);
      pin("t3_err", 32'(err), 32'(m_err), 1);
      check("t3_locked", 32'(locked), 0);
      cyc(1'b1);
      check("t3_err_clear", 32'(err), 0);
      idle(3); cyc(1'b1);
      check("t3_verify_run", 32'(locked), 0);
      idle(3); cyc(1'b1);
      check("t3_relock_from_verify", 32'(locked), 1);

      // Asynchronous reset mid-cycle while locked.
      idle(2);
      check("t4_phase2", 32'(phase), 2);
      @(posedge clk); #2;
      check("t4_expect_before", 32'(expect_strobe), 1);
      check("t4_phase3", 32'(phase), 3);
      #1 reset = 1'b0;
      #1;
      check("t4_locked_async", 32'(locked), 0);
      check("t4_phase_async", 32'(phase), 0);
      check("t4_err_async", 32'(err), 0);
      check("t4_expect_async", 32'(expect_strobe), 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0);
         check("t4_no_err_after_release", 32'(err), 0);
      end

      // Continuous strobe never locks.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1);
         check("t5_cont_locked", 32'(locked), 0);
         check("t5_cont_err", 32'(err), 0);
      end
      cyc(1'b0);

`ifdef STROBE_ERR_COUNT_EN
      do_reset();
      for (int i = 0; i < 300; i++) begin
         cyc(1'b1); idle(3);
         cyc(1'b1); idle(3);
         cyc(1'b1); idle(4);
      end
      cyc(1'b0);
      pin("t6_err_cnt_sat", 32'(err_cnt), 32'(m_errcnt), 255);
      idle(2);
      check("t6_err_cnt_hold", 32'(err_cnt), 255);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t6_err_cnt_reset", 32'(err_cnt), 0);
      @(negedge clk);
      reset = 1'b1;
      idle(2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
